// File: rtl/rnd_arbiter.sv
// rnd_arbiter: round-robin access to the shared LFSR word. Each granted sample
// is reduced modulo the requester's bound by a W-cycle restoring remainder.
module rnd_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      rnd_in,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] bound,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      rnd_out,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic [KW-1:0]   k_q, k_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    out_q, out_d;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;

  logic [W:0]      t;
  logic            t_ge;
  logic [W-1:0]    step;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Remainder is held at W bits: the bit shifted out into t[W] only feeds the
  // compare, and any accepted difference is below 2^W (or equals t when b=0).
  always_comb begin
    t    = {r_q, x_q[k_q]};
    t_ge = (t >= {1'b0, b_q});
    step = t_ge ? (t[W-1:0] - b_q) : t[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    x_d     = x_q;
    b_d     = b_q;
    r_d     = r_q;
    k_d     = k_q;
    ack_d   = '0;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = REDUCE;
          g_d     = gnt_idx;
          x_d     = rnd_in;
          b_d     = bound[gnt_idx*W +: W];
          r_d     = '0;
          k_d     = KW'(W - 1);
        end
      end
      REDUCE: begin
        r_d = step;
        if (k_q == '0) begin
          state_d    = DONE;
          k_d        = '0;
          ack_d[g_q] = 1'b1;
          out_d      = step;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      x_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      ack_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      x_q     <= x_d;
      b_q     <= b_d;
      r_q     <= r_d;
      k_q     <= k_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
    end
  end

  assign ack     = ack_q;
  assign rnd_out = out_q;
  assign busy    = (state_q != IDLE);

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_ack_pulse:  assert property (@(posedge clk) disable iff (rst) (|ack) |=> !(|ack));

endmodule

// File: tb/tb_rnd_arbiter.sv
// Bench for rnd_arbiter: directed cases with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_rnd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      rnd_in;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bound;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rnd_out;
  logic              busy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  rnd_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .rnd_in (rnd_in),
    .req    (req),
    .bound  (bound),
    .ack    (ack),
    .rnd_out(rnd_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  function automatic int ref_mod(input int x, input int b);
    return (b == 0) ? x : x % b;
  endfunction

  int              m_left = 0;
  int              m_ptr  = 0;
  int              m_g    = 0;
  int              m_res  = 0;
  logic [NREQ-1:0] e_ack  = '0;
  logic [W-1:0]    e_out  = '0;
  logic            e_busy = 1'b0;
  logic            mon_en = 1'b0;
  int              m_pick;
  logic [W-1:0]    m_bsel;

  assign m_pick = pick(req, m_ptr);
  assign m_bsel = bound[m_pick*W +: W];

  // m_left counts the remaining service cycles: W+1 after grant, DONE at 1.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_ptr  <= 0;
      e_ack  <= '0;
      e_out  <= '0;
      e_busy <= 1'b0;
      mon_en <= 1'b1;
    end else if (m_left == 0) begin
      if (|req) begin
        m_g    <= m_pick;
        m_res  <= ref_mod(int'(rnd_in), int'(m_bsel));
        m_left <= W + 1;
        e_busy <= 1'b1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        e_busy <= 1'b0;
        e_ack  <= '0;
        m_ptr  <= (m_g + 1) % NREQ;
      end else if (m_left == 2) begin
        e_ack <= NREQ'(1) << m_g;
        e_out <= W'(m_res);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cmp_ack", 32'(ack), 32'(e_ack));
      chk("cmp_rnd_out", 32'(rnd_out), 32'(e_out));
      chk("cmp_busy", 32'(busy), 32'(e_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input string nm, output int at, output int idx, output logic [W-1:0] val);
    at  = -1;
    idx = -1;
    val = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (|ack) begin
        at  = cyc;
        val = rnd_out;
        for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no ack within 40 cycles, got none expected one", nm);
  endtask

  task automatic serve(input int r, input int x, input int b,
                       output int lat, output int idx, output int val);
    int           t0;
    int           at;
    logic [W-1:0] v;
    @(negedge clk);
    rnd_in          = W'(x);
    bound[r*W +: W] = W'(b);
    req             = '0;
    req[r]          = 1'b1;
    t0              = cyc;
    wait_ack($sformatf("serve_r%0d", r), at, idx, v);
    req = '0;
    lat = at - t0;
    val = int'(v);
  endtask

  function automatic logic [W-1:0] rand_bound();
    case ($urandom_range(4, 0))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return W'(1) << $urandom_range(W - 1, 0);
      default: return W'($urandom_range((1 << W) - 1, 0));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ex_x[5] = '{1023, 1023, 1023, 1023, 5};
  int ex_b[5] = '{1, 0, 1023, 512, 600};
  int ex_r[5] = '{0, 1023, 0, 511, 5};

  initial begin
    int           lat, idx, val, at, prev, t0, b0;
    logic [W-1:0] v;

    rst    = 1'b1;
    req    = '0;
    bound  = '0;
    rnd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_rnd_out", 32'(rnd_out), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    b0  = busy_cnt;

    // Single request: 1000 mod 7.
    serve(0, 1000, 7, lat, idx, val);
    chk("single_latency", lat, 11);
    chk("single_idx", idx, 0);
    chk("single_val", val, 6);
    @(negedge clk);
    chk("single_busy_cycles", busy_cnt - b0, 11);

    // Edge bounds.
    for (int i = 0; i < 5; i++) begin
      serve(1, ex_x[i], ex_b[i], lat, idx, val);
      chk($sformatf("edge_val%0d", i), val, ex_r[i]);
      chk($sformatf("edge_lat%0d", i), lat, 11);
    end

    // Fairness after reset with all requests held.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rnd_in = W'(777);
    req    = '1;
    prev   = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ack("fair_ack", at, idx, v);
      chk($sformatf("fair_idx%0d", k), idx, k % NREQ);
      if (k > 0) chk($sformatf("fair_gap%0d", k), at - prev, 12);
      prev = at;
    end
    req = '0;

    // Pointer rotation: after serving 2, requester 0 wins over 2.
    serve(2, 301, 50, lat, idx, val);
    chk("rot_first_val", val, 1);
    @(negedge clk);
    rnd_in = W'(301);
    req    = 4'b0101;
    wait_ack("rot_a", at, idx, v);
    chk("rot_a_idx", idx, 0);
    chk("rot_a_val", 32'(v), 0);
    req  = 4'b0100;
    prev = at;
    wait_ack("rot_b", at, idx, v);
    chk("rot_b_idx", idx, 2);
    chk("rot_b_gap", at - prev, 12);
    chk("rot_b_val", 32'(v), 1);
    req = '0;

    // Reset during REDUCE cycle 5: request to 3 discarded, ptr back to 0.
    @(negedge clk);
    rnd_in          = W'(200);
    bound[3*W +: W] = W'(13);
    bound[0*W +: W] = W'(11);
    req             = 4'b1001;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk($sformatf("mid_noack%0d", n), 32'(ack), 0);
      chk($sformatf("mid_busy%0d", n), 32'(busy), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_rnd_out", 32'(rnd_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    t0  = cyc;
    wait_ack("mid_regrant", at, idx, v);
    chk("mid_regrant_idx", idx, 0);
    chk("mid_regrant_lat", at - t0, 11);
    chk("mid_regrant_val", 32'(v), 2);
    req = 4'b1000;
    wait_ack("mid_next", at, idx, v);
    chk("mid_next_idx", idx, 3);
    chk("mid_next_val", 32'(v), 5);
    req = '0;

    // Protocol stability: req dropped and bound changed during REDUCE.
    serve(1, 1000, 9, lat, idx, val);
    chk("stab_prev_val", val, 1);
    @(negedge clk);
    rnd_in          = W'(1000);
    bound[1*W +: W] = W'(7);
    req             = 4'b0010;
    t0              = cyc;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("stab_hold%0d", n), 32'(rnd_out), 1);
    end
    req             = '0;
    bound[1*W +: W] = W'(13);
    rnd_in          = W'(555);
    wait_ack("stab_ack", at, idx, v);
    chk("stab_idx", idx, 1);
    chk("stab_val", 32'(v), 6);
    chk("stab_lat", at - t0, 11);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rnd_in = W'($urandom);
      rst    = ($urandom_range(399, 0) == 0);
      for (int r = 0; r < NREQ; r++) begin
        if (req[r]) begin
          if ((ack[r] && $urandom_range(1, 0) == 1) || $urandom_range(63, 0) == 0)
            req[r] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          req[r] = 1'b1;
        end
        if ($urandom_range(5, 0) == 0) bound[r*W +: W] = rand_bound();
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
